// File: rtl/hack_data_memory.sv
// hack_data_memory
// ----------------
// Data-memory stage that sits behind the Hack CPU. It decodes the Hack map
// (RAM 0x0000-0x3FFF, SCREEN 0x4000-0x5FFF, KBD 0x6000), buffers keyboard
// codes in a small FIFO, and offers a second synchronous read port into the
// screen buffer for the display scan-out engine.
//
// Ports
//   clk        in   1   system clock, all state on posedge
//   reset      in   1   asynchronous, active-high reset
//   addressM   in   15  CPU data address
//   outM       in   16  CPU write data
//   writeM     in   1   CPU write strobe
//   inM        out  16  read data to CPU, combinational on addressM
//   kbd_code   in   16  key code from keyboard front end
//   kbd_valid  in   1   kbd_code valid
//   kbd_ready  out  1   FIFO can accept a code (not full)
//   scr_addr   in   13  scan-out word address within SCREEN
//   scr_rd     in   1   scan-out read request
//   scr_data   out  16  scan-out read data, one cycle after scr_rd
//   oob_err    out  1   sticky flag for writes to unmapped space
//
// Build option
//   MEM_BOUNDS_CHECK_EN : when defined, oob_err latches on any write to
//   0x6001-0x7FFF and stays set until reset. When undefined, oob_err is
//   tied low and no compare logic exists.
//
// RAM and SCREEN contents survive reset; only the FIFO control, the
// scan-out register and oob_err are reset.

module hack_data_memory #(
    parameter int RAM_WORDS    = 16384,
    parameter int SCREEN_WORDS = 8192,
    parameter int KBD_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic [15:0] kbd_code,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    input  logic [12:0] scr_addr,
    input  logic        scr_rd,
    output logic [15:0] scr_data,
    output logic        oob_err
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);
    localparam int PTR_W  = $clog2(KBD_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(KBD_DEPTH);

    logic [15:0] ram_mem [RAM_WORDS];
    logic [15:0] scr_mem [SCREEN_WORDS];
    logic [15:0] kbd_mem [KBD_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      scr_data_q, scr_data_d;

    logic              sel_ram, sel_scr, sel_kbd;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_idx;
    logic              fifo_empty, fifo_full;
    logic              push, pop;
    logic              ram_we, scr_we, kbd_we;

    // Address decode: bit 14 clear is RAM, 0b10 in [14:13] is SCREEN,
    // exactly 0x6000 is KBD, everything else in 0x6001-0x7FFF is unmapped.
    always_comb begin
        sel_ram = (addressM[14] == 1'b0);
        sel_scr = (addressM[14:13] == 2'b10);
        sel_kbd = (addressM == 15'h6000);
        ram_idx = addressM[RAM_AW-1:0];
        scr_idx = addressM[SCR_AW-1:0];
    end

    // FIFO control. Push is gated by !full only, so a pop in the same cycle
    // as a full FIFO never lets a new code in. A pop on an empty FIFO is a
    // no-op, which also covers the empty push+pop case.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        push       = kbd_valid && !fifo_full;
        pop        = writeM && sel_kbd && !fifo_empty;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        kbd_ready  = !fifo_full;
    end

    // Storage write enables. A write coinciding with reset is discarded.
    always_comb begin
        ram_we = writeM && sel_ram && !reset;
        scr_we = writeM && sel_scr && !reset;
        kbd_we = push && !reset;
    end

    // Scan-out port: the read samples the array before this edge's CPU
    // write lands, giving read-before-write on a same-word collision.
    always_comb begin
        scr_data_d = scr_data_q;
        if (scr_rd) begin
            scr_data_d = scr_mem[scr_addr[SCR_AW-1:0]];
        end
    end

    // CPU read mux, zero latency.
    always_comb begin
        inM = 16'h0000;
        if (sel_ram) begin
            inM = ram_mem[ram_idx];
        end else if (sel_scr) begin
            inM = scr_mem[scr_idx];
        end else if (sel_kbd && !fifo_empty) begin
            inM = kbd_mem[rd_ptr_q];
        end
    end

    // Array storage, never reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_idx] <= outM;
        end
        if (scr_we) begin
            scr_mem[scr_idx] <= outM;
        end
        if (kbd_we) begin
            kbd_mem[wr_ptr_q] <= kbd_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            scr_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            scr_data_q <= scr_data_d;
        end
    end

    assign scr_data = scr_data_q;

`ifdef MEM_BOUNDS_CHECK_EN
    logic sel_unmapped;
    logic oob_err_q, oob_err_d;

    always_comb begin
        sel_unmapped = (addressM[14:13] == 2'b11) && !sel_kbd;
        oob_err_d    = oob_err_q | (writeM & sel_unmapped);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oob_err_q <= 1'b0;
        end else begin
            oob_err_q <= oob_err_d;
        end
    end

    assign oob_err = oob_err_q;
`else
    assign oob_err = 1'b0;
`endif

endmodule

// File: tb/tb_hack_data_memory.sv
// tb_hack_data_memory
// -------------------
// Self-checking bench for hack_data_memory. A behavioural model (plain
// arrays for RAM/SCREEN, a queue for the keyboard FIFO) predicts inM,
// kbd_ready, scr_data and oob_err. Directed sequences cover the documented
// scenarios, followed by randomized traffic with occasional resets.

module tb_hack_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic [15:0] kbd_code;
    logic        kbd_valid;
    logic        kbd_ready;
    logic [12:0] scr_addr;
    logic        scr_rd;
    logic [15:0] scr_data;
    logic        oob_err;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit OOB_EN = 1'b1;
`else
    localparam bit OOB_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    hack_data_memory dut (
        .clk       (clk),
        .reset     (reset),
        .addressM  (addressM),
        .outM      (outM),
        .writeM    (writeM),
        .inM       (inM),
        .kbd_code  (kbd_code),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready),
        .scr_addr  (scr_addr),
        .scr_rd    (scr_rd),
        .scr_data  (scr_data),
        .oob_err   (oob_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state
    logic [15:0] ram_m [16384];
    bit          ram_k [16384];
    logic [15:0] scr_m [8192];
    bit          scr_k [8192];
    logic [15:0] kq [$];
    logic [15:0] exp_scr;
    bit          scr_known;
    bit          exp_oob;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [14:0] a, output bit known);
        known = 1'b1;
        if (a < 15'h4000) begin
            known = ram_k[a[13:0]];
            return ram_m[a[13:0]];
        end else if (a < 15'h6000) begin
            known = scr_k[a[12:0]];
            return scr_m[a[12:0]];
        end else if (a == 15'h6000) begin
            return (kq.size() != 0) ? kq[0] : 16'h0000;
        end
        return 16'h0000;
    endfunction

    function automatic logic [15:0] exp_ready();
        return (kq.size() < DEPTH) ? 16'd1 : 16'd0;
    endfunction

    // One bus cycle: drive after negedge, check combinational outputs,
    // advance the model at posedge, then check registered outputs.
    task automatic step(input logic [14:0] a, input logic [15:0] d, input logic w,
                        input logic [15:0] kc, input logic kv,
                        input logic [12:0] sa, input logic sr);
        logic [15:0] e;
        bit          kn;
        bit          do_push;
        bit          do_pop;
        @(negedge clk);
        addressM  = a;
        outM      = d;
        writeM    = w;
        kbd_code  = kc;
        kbd_valid = kv;
        scr_addr  = sa;
        scr_rd    = sr;
        #1;
        e = model_rd(a, kn);
        if (kn) chk("inM", inM, e);
        chk("kbd_ready", {15'b0, kbd_ready}, exp_ready());
        @(posedge clk);
        do_push = kv && (kq.size() < DEPTH);
        do_pop  = w && (a == 15'h6000) && (kq.size() != 0);
        if (sr) begin
            scr_known = scr_k[sa];
            exp_scr   = scr_m[sa];
        end
        if (w) begin
            if (a < 15'h4000) begin
                ram_m[a[13:0]] = d;
                ram_k[a[13:0]] = 1'b1;
            end else if (a < 15'h6000) begin
                scr_m[a[12:0]] = d;
                scr_k[a[12:0]] = 1'b1;
            end else if (a != 15'h6000) begin
                exp_oob = exp_oob | OOB_EN;
            end
        end
        if (do_pop) void'(kq.pop_front());
        if (do_push) kq.push_back(kc);
        #1;
        if (scr_known) chk("scr_data", scr_data, exp_scr);
        chk("oob_err", {15'b0, oob_err}, {15'b0, exp_oob});
    endtask

    // Asynchronous reset with a RAM write in flight that must be dropped.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        addressM  = 15'h6000;
        outM      = 16'hDEAD;
        writeM    = 1'b0;
        kbd_valid = 1'b1;
        kbd_code  = 16'h0077;
        scr_rd    = 1'b1;
        scr_addr  = 13'h0005;
        #1;
        kq.delete();
        exp_scr   = 16'h0000;
        scr_known = 1'b1;
        exp_oob   = 1'b0;
        chk("rst_kbd_ready", {15'b0, kbd_ready}, 16'd1);
        chk("rst_scr_data", scr_data, 16'h0000);
        chk("rst_oob_err", {15'b0, oob_err}, 16'd0);
        chk("rst_inM_kbd", inM, 16'h0000);
        addressM = 15'h0003;
        writeM   = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold_scr_data", scr_data, 16'h0000);
        chk("rst_hold_kbd_ready", {15'b0, kbd_ready}, 16'd1);
        @(negedge clk);
        reset     = 1'b0;
        writeM    = 1'b0;
        kbd_valid = 1'b0;
        scr_rd    = 1'b0;
    endtask

    function automatic logic [14:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2, 3: return 15'(15'h0000 + $urandom_range(0, 15));
            4:          return 15'h3FFF;
            5, 6:       return 15'(15'h4000 + $urandom_range(0, 15));
            7:          return 15'h5FFF;
            8:          return 15'h6000;
            default: begin
                case ($urandom_range(0, 2))
                    0:       return 15'h6001;
                    1:       return 15'h7000;
                    default: return 15'h7FFF;
                endcase
            end
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        addressM  = '0;
        outM      = '0;
        writeM    = 1'b0;
        kbd_code  = '0;
        kbd_valid = 1'b0;
        scr_addr  = '0;
        scr_rd    = 1'b0;
        exp_scr   = '0;
        scr_known = 1'b0;
        exp_oob   = 1'b0;
        for (int i = 0; i < 16384; i++) ram_k[i] = 1'b0;
        for (int i = 0; i < 8192; i++) scr_k[i] = 1'b0;

        do_reset();
        step(15'h6000, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);

        // Basic RAM/SCREEN write and read-back
        step(15'h0003, 16'h0BAD, 1'b1, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h4010, 16'hAAAA, 1'b1, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h0010, 16'h1234, 1'b1, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h0010, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h4010, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h3FFF, 16'hC0DE, 1'b1, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h5FFF, 16'hBEEF, 1'b1, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h3FFF, 16'h0, 1'b0, 16'h0, 1'b0, 13'h1FFF, 1'b1);
        step(15'h5FFF, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);

        // Scan-out, including read-before-write collision
        step(15'h4005, 16'hFFFF, 1'b1, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h0000, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0005, 1'b1);
        step(15'h4005, 16'h1111, 1'b1, 16'h0, 1'b0, 13'h0005, 1'b1);
        step(15'h0000, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0005, 1'b1);
        step(15'h0000, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0010, 1'b0);

        // Fill the FIFO, then hold a fifth code while full
        for (int i = 0; i < 4; i++) begin
            step(15'h0000, 16'h0, 1'b0, 16'(16'h0041 + i), 1'b1, 13'h0, 1'b0);
        end
        step(15'h0000, 16'h0, 1'b0, 16'h0045, 1'b1, 13'h0, 1'b0);
        // Pop while full with the source still offering: push not admitted
        step(15'h6000, 16'h9999, 1'b1, 16'h0045, 1'b1, 13'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(15'h6000, 16'h9999, 1'b1, 16'h0, 1'b0, 13'h0, 1'b0);
        end
        step(15'h6000, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);

        // Empty FIFO: simultaneous push and pop keeps the push
        step(15'h6000, 16'h0, 1'b1, 16'h000D, 1'b1, 13'h0, 1'b0);
        step(15'h6000, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);
        // Mid-fill push+pop advances the head
        step(15'h6000, 16'h0, 1'b0, 16'h000E, 1'b1, 13'h0, 1'b0);
        step(15'h6000, 16'h0, 1'b1, 16'h000F, 1'b1, 13'h0, 1'b0);
        step(15'h6000, 16'h0, 1'b1, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h6000, 16'h0, 1'b1, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h6000, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);

        // Unmapped region: writes dropped, reads zero
        step(15'h7000, 16'h5555, 1'b1, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h7000, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h6001, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h0003, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);

        // Reset mid-operation: FIFO emptied, in-flight RAM write lost
        step(15'h0000, 16'h0, 1'b0, 16'h0021, 1'b1, 13'h0, 1'b0);
        step(15'h0000, 16'h0, 1'b0, 16'h0022, 1'b1, 13'h0005, 1'b1);
        do_reset();
        step(15'h0003, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);
        step(15'h6000, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                logic [14:0] a;
                logic [12:0] sa;
                a = rand_addr();
                sa = ($urandom_range(0, 16) == 16) ? 13'h1FFF : 13'($urandom_range(0, 15));
                step(a, 16'($urandom), ($urandom_range(0, 2) == 0),
                     16'($urandom), ($urandom_range(0, 1) == 1),
                     sa, ($urandom_range(0, 1) == 1));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
